i2c_switch_cfg_slave: RTL
=========================

Name: i2c_switch_cfg_slave

Overview:
I2C slave configuration port that sets the 12-bit downstream switch-enable vector consumed by the I2C switch controller (switch1..12_enable_control). It sits on the upstream management bus (i2c_scl/i2c_sda) at a fixed 7-bit address, oversampled by the system clock. It accepts a 2-byte write of the enable mask, commits the mask atomically at STOP, and supports a read-back of the committed mask.

Parameters:
SLV_ADDR, 7'h70, 7-bit slave address matched after START
DEFAULT_EN, 12'h000, switch_en value after reset
SYNC_STAGES, 2, flops in the SCL/SDA input synchronisers (min 2)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous active-low reset
scl_in  in  1  upstream SCL sample (asynchronous)
sda_in  in  1  upstream SDA sample (asynchronous)
sda_oen  out  1  SDA output enable, active-low: 0 = pull SDA low, 1 = release
switch_en  out  12  committed enable mask, bit n-1 = switch n
cfg_update  out  1  one-clk pulse when switch_en is loaded from a write
busy  out  1  high from address match until STOP or repeated START

Behaviour:
- Reset (rst=0, async): sda_oen=1, switch_en=DEFAULT_EN, cfg_update=0, busy=0, state=IDLE, shadow=DEFAULT_EN, byte_idx=0.
- Input path: scl_in and sda_in each pass through SYNC_STAGES flops. Edges are detected on the synchronised signals with one extra registered copy, giving 1 clk of edge latency after the sync stages.
- START: sync SDA falls while sync SCL=1. STOP: sync SDA rises while sync SCL=1. Both are recognised in any state, and START takes priority over bit sampling in the same clk.
- Data bits are sampled on SCL rising edges, MSB first. sda_oen changes only on SCL falling edges, except at reset, START or STOP, where it releases immediately.
- States:
  - IDLE: wait for START. START -> ADDR, bit_cnt=0.
  - ADDR: shift 8 bits. On the 8th bit:
    - addr[7:1]==SLV_ADDR -> ADDR_ACK, busy=1, byte_idx=0, rw latched.
    - Otherwise -> IGNORE.
  - ADDR_ACK: drive sda_oen=0 from the next SCL fall to the following SCL fall, then go to WR_DATA (rw=0) or RD_DATA (rw=1).
  - WR_DATA: shift 8 bits, then go to WR_ACK.
    - byte_idx=0: shadow[7:0]=byte.
    - byte_idx=1: shadow[11:8]=byte[3:0], byte[7:4] ignored, wr_pend=1.
    - byte_idx>=2: byte discarded.
  - WR_ACK: ACK (sda_oen=0) for byte_idx 0 and 1; NACK (release) for byte_idx>=2. byte_idx saturates at 2. Return to WR_DATA.
  - RD_DATA: shift out one byte, driving sda_oen = bit value on SCL fall.
    - byte_idx=0: switch_en[7:0].
    - byte_idx=1: {4'h0, switch_en[11:8]}.
    - byte_idx>=2: 8'hFF.
    After the 8th bit, release SDA and go to RD_ACK.
  - RD_ACK: sample the master's ACK on SCL rise. ACK (0) -> RD_DATA with byte_idx+1. NACK (1) -> IGNORE.
  - IGNORE: sda_oen=1 until START or STOP.
- STOP in any state -> IDLE, busy=0. If wr_pend=1: switch_en<=shadow and cfg_update=1 for exactly one clk, the clk after STOP detection. wr_pend is then cleared.
- Repeated START -> ADDR. wr_pend is kept, so the commit still waits for STOP. shadow is kept.
- A write with only one data byte sets no wr_pend, so switch_en is unchanged.
- Reset mid-transaction: everything returns to reset values immediately, and the pending shadow is lost.

Test Plan:
- Reset release -> switch_en=12'h000, sda_oen=1, busy=0. Bus idle 100 clks -> no change.
- START, 0xE0 (0x70 W), 0x5A, 0x0C, STOP -> ACK on all three bytes. switch_en stays 0x000 until STOP, then becomes 12'hC5A with cfg_update high for exactly 1 clk.
- Write 0xE0, 0xFF, 0xF3, 0x11, STOP -> third data byte NACKed. switch_en=12'h3FF.
- START 0xE2 (wrong address), 0x12, 0x34, STOP -> sda_oen stays 1 throughout, busy=0, switch_en unchanged.
- With switch_en=12'hC5A: START, 0xE1, master ACKs byte 0 and NACKs byte 1 -> bytes read 0x5A then 0x0C. SDA released after NACK, busy=0 after STOP.
- Write 0xE0, 0x01, 0x08, repeated START, 0xE1, read 2 bytes, STOP -> read returns the old mask. New mask 12'h801 commits only at STOP.
- Assert rst after the first data byte of a write -> sda_oen=1 immediately, switch_en=DEFAULT_EN, no cfg_update.

Source files
------------

// File: rtl/i2c_switch_cfg_slave.sv
// I2C slave that holds the 12-bit downstream switch-enable mask.
// Writes land in a shadow register and commit atomically at STOP; reads return the committed mask.
module i2c_switch_cfg_slave #(
    parameter logic [6:0]  SLV_ADDR    = 7'h70,
    parameter logic [11:0] DEFAULT_EN  = 12'h000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oen,
    output logic [11:0] switch_en,
    output logic        cfg_update,
    output logic        busy
);

    localparam int unsigned NSync = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        StIdle, StAddr, StAddrAck, StWrData, StWrAck, StRdData, StRdAck, StIgnore
    } state_e;

    logic [NSync-1:0] scl_sync_q, sda_sync_q;
    logic             scl_d1_q, sda_d1_q;
    logic             scl_s, sda_s;
    logic             scl_rise, scl_fall, start_det, stop_det;

    state_e      state_q;
    logic [3:0]  bit_cnt_q;
    logic [6:0]  shift_q;
    logic [7:0]  tx_q;
    logic [1:0]  byte_idx_q;
    logic [11:0] shadow_q;
    logic [11:0] switch_en_q;
    logic        wr_pend_q, rw_q, phase_q;
    logic        sda_oen_q, cfg_update_q, busy_q;

    logic [1:0]  nxt_idx;
    logic [7:0]  rd_cur, rd_nxt;

    function automatic logic [7:0] rd_byte(input logic [1:0] idx, input logic [11:0] en);
        case (idx)
            2'd0:    return en[7:0];
            2'd1:    return {4'h0, en[11:8]};
            default: return 8'hFF;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_d1_q   <= 1'b1;
            sda_d1_q   <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[NSync-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[NSync-2:0], sda_in};
            scl_d1_q   <= scl_sync_q[NSync-1];
            sda_d1_q   <= sda_sync_q[NSync-1];
        end
    end

    assign scl_s     = scl_sync_q[NSync-1];
    assign sda_s     = sda_sync_q[NSync-1];
    assign scl_rise  = scl_s & ~scl_d1_q;
    assign scl_fall  = ~scl_s & scl_d1_q;
    assign start_det = scl_s & sda_d1_q & ~sda_s;
    assign stop_det  = scl_s & ~sda_d1_q & sda_s;

    assign nxt_idx = (byte_idx_q == 2'd2) ? 2'd2 : byte_idx_q + 2'd1;
    assign rd_cur  = rd_byte(byte_idx_q, switch_en_q);
    assign rd_nxt  = rd_byte(nxt_idx, switch_en_q);

    // phase_q marks the second half of an ACK slot (ACK driven / master ACK seen).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            bit_cnt_q    <= 4'd0;
            shift_q      <= 7'd0;
            tx_q         <= 8'hFF;
            byte_idx_q   <= 2'd0;
            shadow_q     <= DEFAULT_EN;
            switch_en_q  <= DEFAULT_EN;
            wr_pend_q    <= 1'b0;
            rw_q         <= 1'b0;
            phase_q      <= 1'b0;
            sda_oen_q    <= 1'b1;
            cfg_update_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            cfg_update_q <= 1'b0;
            if (start_det) begin
                state_q   <= StAddr;
                bit_cnt_q <= 4'd0;
                phase_q   <= 1'b0;
                sda_oen_q <= 1'b1;
                busy_q    <= 1'b0;
            end else if (stop_det) begin
                state_q   <= StIdle;
                phase_q   <= 1'b0;
                sda_oen_q <= 1'b1;
                busy_q    <= 1'b0;
                if (wr_pend_q) begin
                    switch_en_q  <= shadow_q;
                    cfg_update_q <= 1'b1;
                    wr_pend_q    <= 1'b0;
                end
            end else begin
                case (state_q)
                    StAddr: begin
                        if (scl_rise) begin
                            shift_q   <= {shift_q[5:0], sda_s};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                phase_q <= 1'b0;
                                if (shift_q == SLV_ADDR) begin
                                    state_q    <= StAddrAck;
                                    busy_q     <= 1'b1;
                                    byte_idx_q <= 2'd0;
                                    rw_q       <= sda_s;
                                end else begin
                                    state_q <= StIgnore;
                                end
                            end
                        end
                    end
                    StAddrAck: begin
                        if (scl_fall) begin
                            if (!phase_q) begin
                                sda_oen_q <= 1'b0;
                                phase_q   <= 1'b1;
                            end else begin
                                phase_q   <= 1'b0;
                                bit_cnt_q <= 4'd0;
                                if (rw_q) begin
                                    state_q   <= StRdData;
                                    sda_oen_q <= rd_cur[7];
                                    tx_q      <= {rd_cur[6:0], 1'b1};
                                end else begin
                                    state_q   <= StWrData;
                                    sda_oen_q <= 1'b1;
                                end
                            end
                        end
                    end
                    StWrData: begin
                        if (scl_rise) begin
                            shift_q   <= {shift_q[5:0], sda_s};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                state_q <= StWrAck;
                                phase_q <= 1'b0;
                                if (byte_idx_q == 2'd0) begin
                                    shadow_q[7:0] <= {shift_q, sda_s};
                                end else if (byte_idx_q == 2'd1) begin
                                    shadow_q[11:8] <= {shift_q[2:0], sda_s};
                                    wr_pend_q      <= 1'b1;
                                end
                            end
                        end
                    end
                    StWrAck: begin
                        if (scl_fall) begin
                            if (!phase_q) begin
                                sda_oen_q <= (byte_idx_q == 2'd2);
                                phase_q   <= 1'b1;
                            end else begin
                                sda_oen_q  <= 1'b1;
                                phase_q    <= 1'b0;
                                bit_cnt_q  <= 4'd0;
                                byte_idx_q <= nxt_idx;
                                state_q    <= StWrData;
                            end
                        end
                    end
                    StRdData: begin
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                sda_oen_q <= 1'b1;
                                phase_q   <= 1'b0;
                                state_q   <= StRdAck;
                            end else begin
                                sda_oen_q <= tx_q[7];
                                tx_q      <= {tx_q[6:0], 1'b1};
                            end
                        end
                    end
                    StRdAck: begin
                        if (scl_rise) begin
                            if (sda_s) begin
                                state_q <= StIgnore;
                            end else begin
                                phase_q <= 1'b1;
                            end
                        end else if (scl_fall && phase_q) begin
                            phase_q    <= 1'b0;
                            bit_cnt_q  <= 4'd0;
                            byte_idx_q <= nxt_idx;
                            sda_oen_q  <= rd_nxt[7];
                            tx_q       <= {rd_nxt[6:0], 1'b1};
                            state_q    <= StRdData;
                        end
                    end
                    StIgnore: begin
                        sda_oen_q <= 1'b1;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign sda_oen    = sda_oen_q;
    assign switch_en  = switch_en_q;
    assign cfg_update = cfg_update_q;
    assign busy       = busy_q;

endmodule
